// File: rtl/aes_pkg.sv
// Constants and state encoding shared by the AES encrypt and decrypt datapaths.
package aes_pkg;

    localparam int unsigned AES_BYTES   = 16;
    localparam int unsigned AES_STATE_W = 8 * AES_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } aes_state_e;

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, its InvSubBytes image out.
module inv_sbox (
    input  logic [7:0] in,
    output logic [7:0] out
);

    // Entry 0x00 sits in the most significant byte, entry 0xff in the least.
    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry i lives at bit offset (255 - i) * 8, i.e. {~in, 3'b000}.
    logic [10:0] idx;

    assign idx = {~in, 3'b000};
    assign out = INV_TABLE[idx +: 8];

endmodule

// File: rtl/inv_subbytes_iter.sv
// Iterative InvSubBytes stage: BYTES_PER_CYCLE inverse S-boxes walk the 128-bit state
// MSB group first, with valid/ready handshakes on both sides.
module inv_subbytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out
);

    localparam int unsigned NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int unsigned GROUP_W   = 8 * BYTES_PER_CYCLE;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    aes_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] work_q, work_d;

    logic [NUM_STEPS-1:0]   sel;
    logic [GROUP_W-1:0]     groups [NUM_STEPS];
    logic [GROUP_W-1:0]     group_in, group_out;
    logic [AES_STATE_W-1:0] work_upd;

    // Group 0 is the most significant GROUP_W bits of the working register.
    for (genvar g = 0; g < NUM_STEPS; g++) begin : g_group
        assign sel[g]    = (cnt_q == CNT_W'(g));
        assign groups[g] = work_q[AES_STATE_W-1-g*GROUP_W -: GROUP_W];
        assign work_upd[AES_STATE_W-1-g*GROUP_W -: GROUP_W] = sel[g] ? group_out : groups[g];
    end

    always_comb begin
        group_in = '0;
        for (int unsigned g = 0; g < NUM_STEPS; g++) begin
            if (sel[g]) begin
                group_in = groups[g];
            end
        end
    end

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in  (group_in[8*b +: 8]),
            .out (group_out[8*b +: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    work_d  = in;
                end
            end
            BUSY: begin
                work_d = work_upd;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = work_q;

endmodule
